branch_target_predictor: RTL and testbench

//  Direct-mapped branch target buffer with per-entry valid bit and saturating direction counter.
//  IF stage: looks up current_pc combinationally and drives next_pc.
//  EX/MEM stage: writes resolved branch outcomes back through the update port.

---
 rtl/branch_target_predictor.sv | 80 ++++++++
 tb/tb_branch_target_predictor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with valid bits, direction counters and flush
module branch_target_predictor #(
    parameter int ENTRIES  = 32,
    parameter int CNT_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic        btb_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] next_pc,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        flush
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 32 - IDX_BITS - 2;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_MAX ^ (CNT_MAX >> 1);

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_hit;

    assign lk_idx = current_pc[IDX_BITS+1:2];
    assign lk_tag = current_pc[31:IDX_BITS+2];
    assign up_idx = update_pc[IDX_BITS+1:2];
    assign up_tag = update_pc[31:IDX_BITS+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Zero-latency lookup; reads stored state only, so a same-cycle update is not bypassed
    always_comb begin
        btb_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_target = btb_hit ? target_q[lk_idx] : 32'd0;
        pred_taken  = btb_hit && cnt_q[lk_idx][CNT_BITS-1];
        next_pc     = pred_taken ? pred_target : current_pc + 32'd4;
    end

    // Table state: reset clears everything, flush beats update, update trains or allocates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    target_q[up_idx] <= update_target;
                    if (cnt_q[up_idx] != CNT_MAX)
                        cnt_q[up_idx] <= cnt_q[up_idx] + 1'b1;
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_q[up_idx] <= cnt_q[up_idx] - 1'b1;
                end
            end else if (update_taken) begin
                // Only taken branches allocate; a not-taken miss leaves the victim alone
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
                cnt_q[up_idx]    <= CNT_WEAK;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] next_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        flush;

    int tests = 0;
    int fails = 0;

    branch_target_predictor #(.ENTRIES(32), .CNT_BITS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .current_pc    (current_pc),
        .btb_hit       (btb_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .next_pc       (next_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a lookup PC and compare all four lookup outputs
    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt, input logic [31:0] npc);
        current_pc = pc;
        #1;
        check({tag, ".hit"},    32'(btb_hit),    32'(hit));
        check({tag, ".taken"},  32'(pred_taken), 32'(taken));
        check({tag, ".target"}, pred_target,     tgt);
        check({tag, ".next"},   next_pc,         npc);
    endtask

    // One update applied at the next rising edge, inputs released 1ns after it
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update_valid  = 1'b1;
        update_pc     = pc;
        update_taken  = taken;
        update_target = tgt;
        @(posedge clk);
        #1;
        update_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; current_pc = 32'h100; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("rst", 32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Allocate weakly taken
        upd(32'h100, 1'b1, 32'h200);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200, 32'h200);
        look("lowbits", 32'h103, 1'b1, 1'b1, 32'h200, 32'h200);

        // Counter training: 2 -> 1 -> 0, then up to saturation and back
        upd(32'h100, 1'b0, 32'hDEAD);
        look("cnt1", 32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        upd(32'h100, 1'b0, 32'hDEAD);
        look("cnt0", 32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        upd(32'h100, 1'b0, 32'hDEAD);
        upd(32'h100, 1'b1, 32'h200);
        look("cnt0to1", 32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h240);
        look("sat", 32'h100, 1'b1, 1'b1, 32'h240, 32'h240);
        upd(32'h100, 1'b0, 32'hDEAD);
        look("sat_nt1", 32'h100, 1'b1, 1'b1, 32'h240, 32'h240);
        upd(32'h100, 1'b0, 32'hDEAD);
        look("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h240, 32'h104);

        // Aliasing at index 0
        upd(32'h180, 1'b1, 32'h300);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        look("alias_new", 32'h180, 1'b1, 1'b1, 32'h300, 32'h300);
        upd(32'h100, 1'b0, 32'h0);
        look("alias_keep", 32'h180, 1'b1, 1'b1, 32'h300, 32'h300);

        // Same-cycle lookup/update of the same entry: no bypass
        current_pc    = 32'h140;
        update_valid  = 1'b1;
        update_pc     = 32'h140;
        update_taken  = 1'b1;
        update_target = 32'h500;
        #1;
        check("nobypass.hit",  32'(btb_hit), 32'd0);
        check("nobypass.next", next_pc,      32'h144);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        look("after_bypass", 32'h140, 1'b1, 1'b1, 32'h500, 32'h500);

        // Flush beats a simultaneous update
        flush = 1'b1;
        upd(32'h100, 1'b1, 32'h600);
        flush = 1'b0;
        look("flush100", 32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        look("flush140", 32'h140, 1'b0, 1'b0, 32'h0, 32'h144);
        look("flush180", 32'h180, 1'b0, 1'b0, 32'h0, 32'h184);

        // Fresh allocation after flush is weakly taken
        upd(32'h140, 1'b1, 32'h700);
        look("realloc", 32'h140, 1'b1, 1'b1, 32'h700, 32'h700);
        upd(32'h140, 1'b0, 32'h0);
        look("weak_nt", 32'h140, 1'b1, 1'b0, 32'h700, 32'h144);

        // Asynchronous reset between edges, with an update pending
        update_valid  = 1'b1;
        update_pc     = 32'h1C0;
        update_taken  = 1'b1;
        update_target = 32'h800;
        reset = 1'b1;
        #1;
        check("async_rst.hit",  32'(btb_hit), 32'd0);
        check("async_rst.next", next_pc,      32'h144);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        look("rst_lost_upd", 32'h1C0, 1'b0, 1'b0, 32'h0, 32'h1C4);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
